muldiv_iter_unit: RTL

Iterative RV32M execution unit that sits directly downstream of the core's issue/operand-read stage. It consumes a decoded M-extension operation and two 32-bit source register values and produces the 32-bit result written back to rd. Multiplies use a 2-cycle pipelined 33x33 signed multiplier. Divides and remainders use a fixed-latency 32-iteration restoring divider, so the writeback path always sees a deterministic latency per operation class.

---
 rtl/muldiv_iter_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M unit: 2-cycle multiplier and 32-step restoring divider.
// Fixed latency per class so writeback scheduling stays deterministic.
module muldiv_iter_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] operand_ra_i,
    input  logic [31:0] operand_rb_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        ready_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [31:0] r_ra;
    logic [31:0] r_rb;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic [5:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic        r_busy;
    logic        r_ready;
    logic [31:0] r_result;

    logic        w_a_sx;
    logic        w_b_sx;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic [31:0] w_mul_res;

    logic        w_sdiv;
    logic [31:0] w_ra_mag;
    logic [31:0] w_rb_mag;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic [31:0] w_div_res;

    // Low 64 bits of the 33x33 signed product are all any M op selects.
    assign w_a_sx    = (r_op != 2'b11) & r_ra[31];
    assign w_b_sx    = ~r_op[1] & r_rb[31];
    assign w_a64     = {{32{w_a_sx}}, r_ra};
    assign w_b64     = {{32{w_b_sx}}, r_rb};
    assign w_prod    = w_a64 * w_b64;
    assign w_mul_res = (r_op == 2'b00) ? w_prod[31:0] : w_prod[63:32];

    assign w_sdiv   = ~op_i[0];
    assign w_ra_mag = (w_sdiv & operand_ra_i[31]) ? -operand_ra_i : operand_ra_i;
    assign w_rb_mag = (w_sdiv & operand_rb_i[31]) ? -operand_rb_i : operand_rb_i;

    // Dividend bits shift out of the top of r_quo as quotient bits shift in.
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_ge     = w_rem_sh >= {1'b0, r_div};
    assign w_sub    = w_rem_sh[31:0] - r_div;
    assign w_rem_nx = w_ge ? w_sub : w_rem_sh[31:0];
    assign w_quo_nx = {r_quo[30:0], w_ge};

    assign w_q_fix   = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_r_fix   = r_neg_r ? -w_rem_nx : w_rem_nx;
    assign w_div_res = r_dz ? (r_op[1] ? r_ra : 32'hFFFF_FFFF)
                            : (r_op[1] ? w_r_fix : w_q_fix);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_ra     <= '0;
            r_rb     <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (valid_i) begin
                        r_op    <= op_i[1:0];
                        r_ra    <= operand_ra_i;
                        r_rb    <= operand_rb_i;
                        r_quo   <= w_ra_mag;
                        r_rem   <= '0;
                        r_div   <= w_rb_mag;
                        r_neg_q <= w_sdiv & (operand_ra_i[31] ^ operand_rb_i[31]);
                        r_neg_r <= w_sdiv & operand_ra_i[31];
                        r_dz    <= (operand_rb_i == 32'd0);
                        r_busy  <= 1'b1;
                        if (op_i[2]) begin
                            r_state <= S_DIV;
                            r_cnt   <= 6'd32;
                        end else begin
                            r_state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    r_result <= w_mul_res;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_DONE;
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_result <= w_div_res;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign ready_o  = r_ready;
    assign result_o = r_result;

endmodule
